display_scan_controller: RTL and testbench



---
 rtl/display_scan_controller.sv | 127 ++++++++++++
 tb/tb_display_scan_controller.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// 4-digit common-anode 7-segment scanner with blanking gaps; DISPLAY_SCAN_LZB_EN adds leading-zero blanking.
// Latency: an_n/seg_n registered with state; a value accepted now is shown from the first frame after the next boundary.
// Backpressure: in_ready drops while one value is pending and returns once that value is applied at a frame boundary.
module display_scan_controller #(
   parameter int PRESCALE     = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [15:0] in_bcd,
   output logic        in_ready,
   output logic [3:0]  an_n,
   output logic [6:0]  seg_n,
   output logic        frame_done
);

   localparam int CMAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic {BLANK, SHOW} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [1:0]    digit_idx, idx_nxt;
   logic [15:0]   active, pending;
   logic          pending_full;
   logic [3:0]    an_nxt;
   logic [6:0]    seg_nxt;
   logic [3:0]    nibble;
   logic          lz_blank;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'h40;
         4'd1:    decode = 7'h79;
         4'd2:    decode = 7'h24;
         4'd3:    decode = 7'h30;
         4'd4:    decode = 7'h19;
         4'd5:    decode = 7'h12;
         4'd6:    decode = 7'h02;
         4'd7:    decode = 7'h78;
         4'd8:    decode = 7'h00;
         4'd9:    decode = 7'h10;
         default: decode = 7'h3F;
      endcase
   endfunction

   assign in_ready = !pending_full;

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt + CW'(1);
      idx_nxt    = digit_idx;
      frame_done = 1'b0;
      case (state)
         BLANK: begin
            if (cnt == CW'(BLANK_CYCLES - 1)) begin
               state_nxt = SHOW;
               cnt_nxt   = '0;
            end
         end
         default: begin
            if (cnt == CW'(PRESCALE - 1)) begin
               state_nxt  = BLANK;
               cnt_nxt    = '0;
               idx_nxt    = digit_idx + 2'd1;
               frame_done = (digit_idx == 2'd3);
            end
         end
      endcase
   end

   // Outputs are computed for the next state so they register on the same edge.
   always_comb begin
      case (idx_nxt)
         2'd0:    nibble = active[3:0];
         2'd1:    nibble = active[7:4];
         2'd2:    nibble = active[11:8];
         default: nibble = active[15:12];
      endcase
`ifdef DISPLAY_SCAN_LZB_EN
      case (idx_nxt)
         2'd0:    lz_blank = 1'b0;
         2'd1:    lz_blank = (active[15:4] == 12'h000);
         2'd2:    lz_blank = (active[15:8] == 8'h00);
         default: lz_blank = (active[15:12] == 4'h0);
      endcase
`else
      lz_blank = 1'b0;
`endif
      an_nxt  = 4'b1111;
      seg_nxt = 7'h7F;
      if (state_nxt == SHOW && !lz_blank) begin
         an_nxt  = ~(4'b0001 << idx_nxt);
         seg_nxt = decode(nibble);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= BLANK;
         cnt          <= '0;
         digit_idx    <= 2'd0;
         active       <= 16'h0000;
         pending      <= 16'h0000;
         pending_full <= 1'b0;
         an_n         <= 4'b1111;
         seg_n        <= 7'h7F;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         digit_idx <= idx_nxt;
         an_n      <= an_nxt;
         seg_n     <= seg_nxt;
         // A write in the boundary cycle only fills pending; it waits a full frame.
         if (frame_done && pending_full) begin
            active       <= pending;
            pending_full <= 1'b0;
         end else if (in_valid && !pending_full) begin
            pending      <= in_bcd;
            pending_full <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: directed scenarios plus random writes against a frame-position model.
module tb_display_scan_controller;

   localparam int PRESCALE = 4;
   localparam int BLANK    = 2;
   localparam int SLOT     = PRESCALE + BLANK;
   localparam int FRAME    = 4 * SLOT;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_bcd = 16'h0000;
   logic        in_ready;
   logic [3:0]  an_n;
   logic [6:0]  seg_n;
   logic        frame_done;

   int errors = 0;
   int checks = 0;

   int          t;
   logic [15:0] m_act, m_pend;
   bit          m_full;
   logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

   display_scan_controller #(.PRESCALE(PRESCALE), .BLANK_CYCLES(BLANK)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bcd(in_bcd),
      .in_ready(in_ready), .an_n(an_n), .seg_n(seg_n), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
      end
   endtask

   task automatic model_reset();
      t = 0;
      m_act = 16'h0000;
      m_pend = 16'h0000;
      m_full = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      in_valid = 1'b0;
      @(posedge clk); #1;
      for (int i = 1; i < n; i++) begin
         @(negedge clk);
         check("rst_an", {12'h0, an_n}, 16'hF);
         check("rst_seg", {9'h0, seg_n}, 16'h7F);
         check("rst_fd", {15'h0, frame_done}, 16'h0);
         check("rst_rdy", {15'h0, in_ready}, 16'h1);
         @(posedge clk); #1;
      end
      rst_n = 1'b1;
      model_reset();
   endtask

   // One clock cycle: drive, compare against the frame-position model, advance model.
   task automatic cycle(input bit v, input logic [15:0] d);
      int p, slot, off;
      logic [15:0] upper;
      logic [3:0]  exp_an;
      logic [6:0]  exp_seg;
      bit blank;
      in_valid = v;
      in_bcd = d;
      @(negedge clk);
      p = t % FRAME;
      slot = p / SLOT;
      off = p % SLOT;
      exp_an = 4'hF;
      exp_seg = 7'h7F;
      upper = m_act >> (4 * slot);
      blank = 1'b0;
`ifdef DISPLAY_SCAN_LZB_EN
      blank = (slot > 0) && (upper == 16'h0);
`endif
      if (off >= BLANK && !blank) begin
         exp_an = ~(4'b0001 << slot);
         exp_seg = seg_tab[upper[3:0]];
      end
      check("an_n", {12'h0, an_n}, {12'h0, exp_an});
      check("seg_n", {9'h0, seg_n}, {9'h0, exp_seg});
      check("frame_done", {15'h0, frame_done}, {15'h0, (p == FRAME - 1)});
      check("in_ready", {15'h0, in_ready}, {15'h0, !m_full});
      if (p == FRAME - 1 && m_full) begin
         m_act = m_pend;
         m_full = 1'b0;
      end else if (v && !m_full) begin
         m_pend = d;
         m_full = 1'b1;
      end
      t++;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 16'h0000);
   endtask

   task automatic align(input int pos);
      while ((t % FRAME) != pos) cycle(1'b0, 16'h0000);
   endtask

   initial begin
      model_reset();
      do_reset(3);
      idle(FRAME);
      // Mid-frame write, then an ignored write while pending is full.
      align(10);
      cycle(1'b1, 16'h1234);
      cycle(1'b1, 16'h5678);
      idle(FRAME + 4);
      cycle(1'b1, 16'h5678);
      idle(2 * FRAME);
      // Write landing exactly in the boundary cycle.
      align(FRAME - 1);
      cycle(1'b1, 16'h9999);
      idle(2 * FRAME);
      cycle(1'b1, 16'hABF0);
      idle(2 * FRAME);
      // Reset during SHOW of digit 2.
      align(2 * SLOT + BLANK + 1);
      do_reset(1);
      idle(3);
      cycle(1'b1, 16'h0070);
      idle(2 * FRAME);
      cycle(1'b1, 16'h0005);
      idle(2 * FRAME);
      cycle(1'b1, 16'h0300);
      idle(2 * FRAME);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) cycle(1'b1, 16'($urandom));
         else cycle(1'b0, 16'($urandom));
         if (i == 1500) do_reset(2);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
